// File: rtl/riscv_types.sv
// riscv_types: atomic-op encodings, request bundle and responder FSM states shared with the cores.
package riscv_types;
  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} amo_state_t;
  localparam int HART_W = 8;
  typedef struct packed {
    logic [HART_W-1:0] hart;
    amo_t              op;
    logic [31:0]       addr;
    logic [31:0]       data;
  } amo_req_t;
  function automatic logic amo_known(input logic [4:0] op);
    return op inside {AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
                      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};
  endfunction
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational read-modify-write result for an atomic op; SWAP and SC pass rs2 through.
module amo_alu
  import riscv_types::*;
(
  input  amo_t        op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] new_o
);
  logic lt_s, lt_u;
  assign lt_s = $signed(old_i) < $signed(rs2_i);
  assign lt_u = old_i < rs2_i;
  always_comb begin
    case (op_i)
      AMO_ADD:  new_o = old_i + rs2_i;
      AMO_XOR:  new_o = old_i ^ rs2_i;
      AMO_AND:  new_o = old_i & rs2_i;
      AMO_OR:   new_o = old_i | rs2_i;
      AMO_MIN:  new_o = lt_s ? old_i : rs2_i;
      AMO_MAX:  new_o = lt_s ? rs2_i : old_i;
      AMO_MINU: new_o = lt_u ? old_i : rs2_i;
      AMO_MAXU: new_o = lt_u ? rs2_i : old_i;
      default:  new_o = rs2_i;
    endcase
  end
endmodule

// File: rtl/amo_responder.sv
// amo_responder: single-outstanding atomic memory responder with per-hart LR/SC reservations.
module amo_responder
  import riscv_types::*;
#(
  parameter  int NUM_HARTS = 2,
  localparam int HW = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [HW-1:0] req_hart,
  input  logic [4:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [HW-1:0] rsp_hart,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  input  logic          snoop_valid,
  input  logic [31:0]   snoop_addr
);
  amo_state_t           state_q, state_d;
  amo_req_t             req_q, req_d;
  logic [31:0]          old_q, old_d, alu_new;
  logic                 err_q, err_d;
  logic [NUM_HARTS-1:0] rv_q, rv_d;
  logic [29:0]          ra_q [NUM_HARTS];
  logic [29:0]          ra_d [NUM_HARTS];
  logic accept, bad, is_sc, sc_hit, snoop_req, ack_rd, ack_wr, set, clr;

  amo_alu u_alu (.op_i(req_q.op), .old_i(old_q), .rs2_i(req_q.data), .new_o(alu_new));

  assign accept    = req_valid && state_q == IDLE;
  assign bad       = req_addr[1:0] != 2'b00 || !amo_known(req_op);
  assign is_sc     = req_op == AMO_SC;
  assign snoop_req = snoop_valid && (snoop_addr & ~32'h3) == (req_addr & ~32'h3);
  // A snoop hitting the SC word in the accept cycle has already killed the reservation.
  assign sc_hit    = rv_q[req_hart] && ra_q[req_hart] == req_addr[31:2] && !snoop_req;
  assign ack_rd    = state_q == READ && mem_ack;
  assign ack_wr    = state_q == WRITE && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
      rv_q    <= '0;
      ra_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      old_q   <= old_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      ra_q    <= ra_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad ? RESP : is_sc ? (sc_hit ? WRITE : RESP) : READ;
      READ:    if (mem_ack) state_d = req_q.op == AMO_LR ? RESP : WRITE;
      WRITE:   if (mem_ack) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = accept ? amo_req_t'{hart: HART_W'(req_hart), op: amo_t'(req_op),
                                addr: req_addr & ~32'h3, data: req_data} : req_q;
    err_d = accept ? bad : err_q;
    old_d = accept ? {31'd0, !bad && !sc_hit} : ack_rd ? mem_rdata : old_q;
    rv_d  = rv_q;
    set   = 1'b0;
    clr   = 1'b0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      set     = ack_rd && req_q.op == AMO_LR && req_q.hart == HART_W'(i);
      ra_d[i] = set ? req_q.addr[31:2] : ra_q[i];
      // Clears win over a same-cycle LR set, so the snoop compares against the incoming address.
      clr     = (snoop_valid && (snoop_addr & ~32'h3) == {ra_d[i], 2'b00})
             || (ack_wr && ra_q[i] == req_q.addr[31:2])
             || (accept && is_sc && req_hart == HW'(i));
      rv_d[i] = clr ? 1'b0 : set ? 1'b1 : rv_q[i];
    end
  end

  always_comb begin
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RESP;
    rsp_err   = state_q == RESP && err_q;
    rsp_hart  = HW'(req_q.hart);
    rsp_data  = old_q;
    mem_req   = state_q == READ || state_q == WRITE;
    mem_we    = state_q == WRITE;
    mem_addr  = req_q.addr;
    mem_wdata = state_q == WRITE ? alu_new : '0;
  end
endmodule
